// File: rtl/lpddr_burst_seq_pkg.sv
// Shared types and constants for the LPDDR burst sequencer.
//   - seq_state_e : sequencer FSM states
//   - strobe_t    : one bit per single-cycle strobe driven towards lpddr_control
//   - BURST_LEN, counter widths
package lpddr_seq_pkg;

    localparam int unsigned BURST_LEN   = 32;
    localparam int unsigned WORD_CNT_W  = 5;
    localparam int unsigned BURST_CNT_W = 8;
    localparam int unsigned STROBE_W    = 8;

    typedef enum logic [3:0] {
        StIdle,
        StWrRst,
        StWFill,
        StWCmd,
        StWDrain,
        StWInc,
        StRdRst,
        StRCmd,
        StRPop,
        StRInc,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic cmd_en_wr;
        logic wr_en_pls;
        logic addr_rst_wr;
        logic addr_inc_wr;
        logic cmd_en_rd;
        logic rd_en_pls;
        logic addr_rst_rd;
        logic addr_inc_rd;
    } strobe_t;

endpackage

// File: rtl/lpddr_burst_seq_strobe_gap.sv
// Single-cycle strobe register with a shared settle counter.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   req_i    : strobes to fire next cycle (caller only requests while ready_o=1)
//   strobe_o : registered strobes, high for exactly one cycle
//   ready_o  : at least Settle low cycles have followed the last strobe
module lpddr_strobe_gap
    import lpddr_seq_pkg::*;
#(
    parameter int unsigned Width  = STROBE_W,
    parameter int unsigned Settle = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] strobe_o,
    output logic             ready_o
);

    localparam int unsigned CntW = $clog2(Settle + 1);

    logic [CntW-1:0] cnt_q;

    // Loading Settle on the request cycle leaves the counter at zero exactly
    // Settle cycles after the strobe itself, so the next request lands on time.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            strobe_o <= '0;
            cnt_q    <= '0;
        end else begin
            strobe_o <= req_i;
            if (|req_i) begin
                cnt_q <= CntW'(Settle);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign ready_o = (cnt_q == '0);

endmodule

// File: rtl/lpddr_burst_seq.sv
// Burst sequencer in front of lpddr_control: packs the s_* word stream into
// 32-word write bursts and unpacks 32-word read bursts onto the m_* stream.
// A transfer is NUM_BURSTS consecutive bursts from the base address.
//   clk_100mhz, sys_rst_n       : clock, synchronous active-low reset
//   c3_calib_done               : memory calibrated; starts ignored otherwise
//   start_wr, start_rd          : one-cycle transfer requests (write wins)
//   s_data/s_valid/s_ready      : write word stream in
//   m_data/m_valid/m_ready      : read word stream out
//   busy, done                  : transfer active, one-cycle completion
//   cmd_en_wr_a .. addr_incA_rd : single-cycle strobes to lpddr_control
//   wr_data_a                   : registered write word
//   wr_empty_a, wr_full_a       : MCB write-FIFO flags
//   rd_data_a, rd_empty_a       : MCB read-FIFO head word and empty flag
module lpddr_burst_seq
    import lpddr_seq_pkg::*;
#(
    parameter int unsigned NUM_BURSTS = 16,
    parameter int unsigned SETTLE     = 3
) (
    input  logic        clk_100mhz,
    input  logic        sys_rst_n,
    input  logic        c3_calib_done,
    input  logic        start_wr,
    input  logic        start_rd,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic        cmd_en_wr_a,
    output logic        wr_en_pls_a,
    output logic        addr_rstA_wr,
    output logic        addr_incA_wr,
    output logic [31:0] wr_data_a,
    input  logic        wr_empty_a,
    input  logic        wr_full_a,
    output logic        cmd_en_rd_a,
    output logic        rd_en_pls_a,
    output logic        addr_rstA_rd,
    output logic        addr_incA_rd,
    input  logic [31:0] rd_data_a,
    input  logic        rd_empty_a
);

    seq_state_e             state_q, state_d;
    strobe_t                req, strobe;
    logic                   gap_ready;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   last_pop_q, last_pop_d;
    logic [31:0]            wr_data_q, wr_data_d;
    logic [31:0]            m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   word_last, burst_last, wr_hs, pop_go;

    lpddr_strobe_gap #(
        .Width  (STROBE_W),
        .Settle (SETTLE)
    ) u_gap (
        .clk_i    (clk_100mhz),
        .rst_ni   (sys_rst_n),
        .req_i    (req),
        .strobe_o (strobe),
        .ready_o  (gap_ready)
    );

    assign word_last  = (word_cnt_q == WORD_CNT_W'(BURST_LEN - 1));
    assign burst_last = (burst_cnt_q == BURST_CNT_W'(NUM_BURSTS - 1));
    assign wr_hs      = s_valid && s_ready;
    // last_pop_q marks that the 32nd word is out and only the hand-off remains
    assign pop_go     = (state_q == StRPop) && !last_pop_q && gap_ready && !rd_empty_a &&
                        !m_valid_q;

    // State register
    always_ff @(posedge clk_100mhz) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (c3_calib_done && start_wr) begin
                    state_d = StWrRst;
                end else if (c3_calib_done && start_rd) begin
                    state_d = StRdRst;
                end
            end
            StWrRst:  if (gap_ready) state_d = StWFill;
            StWFill:  if (wr_hs && word_last) state_d = StWCmd;
            StWCmd:   if (gap_ready) state_d = StWDrain;
            StWDrain: if (gap_ready && wr_empty_a) state_d = StWInc;
            StWInc:   if (gap_ready) state_d = burst_last ? StDone : StWFill;
            StRdRst:  if (gap_ready) state_d = StRCmd;
            StRCmd:   if (gap_ready) state_d = StRPop;
            StRPop:   if (last_pop_q && !m_valid_q) state_d = StRInc;
            StRInc:   if (gap_ready) state_d = burst_last ? StDone : StRCmd;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        req         = '0;
        s_ready     = 1'b0;
        busy        = (state_q != StIdle) && (state_q != StDone);
        done        = (state_q == StDone);
        word_cnt_d  = word_cnt_q;
        burst_cnt_d = burst_cnt_q;
        last_pop_d  = last_pop_q;
        wr_data_d   = wr_data_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q && !m_ready;
        case (state_q)
            StWrRst: begin
                if (gap_ready) begin
                    req.addr_rst_wr = 1'b1;
                    word_cnt_d      = '0;
                    burst_cnt_d     = '0;
                end
            end
            StWFill: begin
                s_ready = gap_ready && !wr_full_a;
                if (s_valid && s_ready) begin
                    req.wr_en_pls = 1'b1;
                    wr_data_d     = s_data;
                    word_cnt_d    = word_cnt_q + 1'b1;
                end
            end
            StWCmd: if (gap_ready) req.cmd_en_wr = 1'b1;
            StWInc: begin
                if (gap_ready) begin
                    req.addr_inc_wr = 1'b1;
                    burst_cnt_d     = burst_cnt_q + 1'b1;
                end
            end
            StRdRst: begin
                if (gap_ready) begin
                    req.addr_rst_rd = 1'b1;
                    word_cnt_d      = '0;
                    burst_cnt_d     = '0;
                    last_pop_d      = 1'b0;
                end
            end
            StRCmd: if (gap_ready) req.cmd_en_rd = 1'b1;
            StRPop: begin
                if (pop_go) begin
                    req.rd_en_pls = 1'b1;
                    m_data_d      = rd_data_a;
                    m_valid_d     = 1'b1;
                    word_cnt_d    = word_cnt_q + 1'b1;
                    last_pop_d    = word_last;
                end else if (last_pop_q && !m_valid_q) begin
                    last_pop_d = 1'b0;
                end
            end
            StRInc: begin
                if (gap_ready) begin
                    req.addr_inc_rd = 1'b1;
                    burst_cnt_d     = burst_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (!sys_rst_n) begin
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            last_pop_q  <= 1'b0;
            wr_data_q   <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_pop_q  <= last_pop_d;
            wr_data_q   <= wr_data_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign wr_data_a    = wr_data_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign cmd_en_wr_a  = strobe.cmd_en_wr;
    assign wr_en_pls_a  = strobe.wr_en_pls;
    assign addr_rstA_wr = strobe.addr_rst_wr;
    assign addr_incA_wr = strobe.addr_inc_wr;
    assign cmd_en_rd_a  = strobe.cmd_en_rd;
    assign rd_en_pls_a  = strobe.rd_en_pls;
    assign addr_rstA_rd = strobe.addr_rst_rd;
    assign addr_incA_rd = strobe.addr_inc_rd;

endmodule
